mul_pp_gen: RTL and testbench



---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_digit_pp.sv | 32 +++
 rtl/mul_pp_gen.sv | 117 +++++++++++
 tb/tb_mul_pp_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier partial-product datapath.
//   MUL_W  - operand width
//   MUL_N  - number of partial products (digits of the multiplier)
//   MUL_PW - width of one partial product / of the final product
//   state_t - sequencing states of mul_pp_gen
//   pp_t    - one partial-product entry at the default width
package mul_pkg;

  localparam int MUL_W  = 64;
  localparam int MUL_N  = 8;
  localparam int MUL_PW = 2 * MUL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef logic [MUL_PW-1:0] pp_t;

endpackage

// File: rtl/mul_digit_pp.sv
// mul_digit_pp: combinational digit partial product.
// Multiplies the full multiplicand by one D-bit digit of the multiplier and
// places the result at the digit's weight inside a 2W-bit word.
// Ports:
//   a     [W-1:0]    multiplicand
//   digit [D-1:0]    one multiplier digit
//   index [KW-1:0]   digit position, selects the shift of D*index bits
//   pp    [2W-1:0]   shifted partial product
module mul_digit_pp
  import mul_pkg::*;
#(
  parameter int W = MUL_W,
  parameter int N = MUL_N,
  localparam int D  = W / N,
  localparam int KW = $clog2(N)
) (
  input  logic [W-1:0]   a,
  input  logic [D-1:0]   digit,
  input  logic [KW-1:0]  index,
  output logic [2*W-1:0] pp
);

  // The W x D product fits exactly in W+D bits.
  logic [W+D-1:0] prod;

  assign prod = {{D{1'b0}}, a} * {{W{1'b0}}, digit};

  // Highest digit index is N-1, so the shifted product still ends below
  // bit 2W; nothing is lost by the shift.
  assign pp = {{(W-D){1'b0}}, prod} << (D * index);

endmodule

// File: rtl/mul_pp_gen.sv
// mul_pp_gen: sequential partial-product generator feeding adder_tree.
// Accepts one W x W unsigned multiply request, builds the N shifted digit
// partial products one per cycle using a single shared W x D multiplier,
// then presents the whole bank until the consumer takes it.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake (in_ready high only in IDLE)
//   op_a, op_b         unsigned operands, sampled on the accept edge
//   pp_valid/pp_ready  bank handshake (pp_valid high only in HOLD)
//   pp [0:N-1]         partial-product bank, 2W bits per entry
module mul_pp_gen
  import mul_pkg::*;
#(
  parameter int N = MUL_N,
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           pp_valid,
  input  logic           pp_ready,
  output logic [2*W-1:0] pp [0:N-1]
);

  localparam int D  = W / N;
  localparam int KW = $clog2(N);
  localparam int PW = 2 * W;

  state_t          state_reg;
  logic [KW-1:0]   k_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;

  logic [W-1:0]    b_shift;
  logic [D-1:0]    digit;
  logic [PW-1:0]   pp_new;
  logic            accept;
  logic            last_digit;

  // Outputs decode straight from the state register, so they follow the
  // asynchronous reset without waiting for a clock.
  assign in_ready   = (state_reg == IDLE);
  assign pp_valid   = (state_reg == HOLD);
  assign accept     = in_valid && in_ready;
  assign last_digit = (k_reg == KW'(N - 1));

  // Current multiplier digit: bring digit k down to the bottom.
  assign b_shift = b_reg >> (D * k_reg);
  assign digit   = b_shift[D-1:0];

  mul_digit_pp #(
    .W (W),
    .N (N)
  ) u_digit_pp (
    .a     (a_reg),
    .digit (digit),
    .index (k_reg),
    .pp    (pp_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            k_reg     <= '0;
            state_reg <= GEN;
          end
        end
        GEN: begin
          if (last_digit) begin
            k_reg     <= '0;
            state_reg <= HOLD;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        HOLD: begin
          if (pp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Partial-product bank. Each entry is its own register: cleared on
  // acceptance, written once in GEN when the digit counter reaches it,
  // and otherwise held (including after the bank has been consumed).
  for (genvar gi = 0; gi < N; gi++) begin : g_bank
    logic [PW-1:0] entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (accept) begin
        entry_reg <= '0;
      end else if ((state_reg == GEN) && (k_reg == KW'(gi))) begin
        entry_reg <= pp_new;
      end
    end

    assign pp[gi] = entry_reg;
  end

endmodule

// File: tb/tb_mul_pp_gen.sv
// tb_mul_pp_gen: directed self-checking bench for mul_pp_gen (N=8, W=64).
// Expected values are hand-computed constants or 128-bit products of the
// applied operands; the bank is reduced here the way adder_tree would.
module tb_mul_pp_gen;
  import mul_pkg::*;

  localparam int N = MUL_N;
  localparam int W = MUL_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         pp_valid;
  logic         pp_ready = 1'b0;
  pp_t          pp [0:N-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_pp_gen #(
    .N (N),
    .W (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .pp_valid (pp_valid),
    .pp_ready (pp_ready),
    .pp       (pp)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pp_t bank_sum();
    pp_t s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + pp[k];
    return s;
  endfunction

  function automatic pp_t full_product(input logic [63:0] a, input logic [63:0] b);
    pp_t wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until pp_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!pp_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  // Present a request while IDLE, let it be accepted, wait for the bank.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, output int cyc);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("busy_after_accept", in_ready, 1'b0);
    wait_valid(cyc);
    $display("txn a=%h b=%h cycles=%0d sum=%h", a, b, cyc, bank_sum());
  endtask

  task automatic consume();
    pp_ready = 1'b1;
    step();
    pp_ready = 1'b0;
    check("consume_valid_drop", pp_valid, 1'b0);
    check("consume_ready_rise", in_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   cyc;
    pp_t  base;
    pp_t  exp_v;
    logic [63:0] ra, rb;

    // Reset state held from time 0.
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_pp_valid", pp_valid, 1'b0);
    for (int k = 0; k < N; k++) check($sformatf("rst_pp%0d", k), pp[k], '0);

    // Release between edges; the very next edge accepts. pp_ready is held
    // high through GEN to show it is ignored there.
    #1 rst_n = 1'b1;
    pp_ready = 1'b1;
    issue(64'd3, 64'h100, cyc);
    check("single_digit_latency", cyc, N);
    for (int k = 0; k < N; k++)
      check($sformatf("single_digit_pp%0d", k), pp[k], (k == 1) ? 128'h300 : 128'h0);
    step();
    pp_ready = 1'b0;
    check("single_digit_consumed", pp_valid, 1'b0);
    check("single_digit_idle", in_ready, 1'b1);
    check("single_digit_pp_kept", pp[1], 128'h300);

    // All-ones operands.
    base = 128'hFE_FFFF_FFFF_FFFF_FF01;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
    check("ones_latency", cyc, N);
    for (int k = 0; k < N; k++) begin
      exp_v = base << (8 * k);
      check($sformatf("ones_pp%0d", k), pp[k], exp_v);
    end
    check("ones_sum", bank_sum(), 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Backpressure in HOLD with a new request pending.
    op_a = 64'h0000_0001_0000_0001;
    op_b = 64'h0200_0000_0000_0003;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_held", pp_valid, 1'b1);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_pp7_held", pp[7], base << 56);
      check("bp_sum_held", bank_sum(), 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    end
    pp_ready = 1'b1;
    step();
    pp_ready = 1'b0;
    check("bp_release_valid", pp_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_new_accepted", in_ready, 1'b0);
    wait_valid(cyc);
    $display("txn a=%h b=%h cycles=%0d sum=%h", op_a, op_b, cyc, bank_sum());
    check("bp_new_latency", cyc, N);
    check("bp_new_pp0", pp[0], 128'h3_0000_0003);
    check("bp_new_pp7", pp[7], 128'h200000002_00000000000000);
    check("bp_new_sum", bank_sum(), 128'h200000002_00000300000003);
    consume();

    // Asynchronous reset mid-cycle while a bank is held.
    issue(64'hAB, 64'h11, cyc);
    check("rsthold_latency", cyc, N);
    check("rsthold_pp0", pp[0], 128'hB5B);
    #2 rst_n = 1'b0;
    #1;
    check("rsthold_in_ready", in_ready, 1'b1);
    check("rsthold_pp_valid", pp_valid, 1'b0);
    for (int k = 0; k < N; k++) check($sformatf("rsthold_pp%0d", k), pp[k], '0);
    #1 rst_n = 1'b1;

    // Zero multiplicand still takes the full N cycles.
    issue(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
    check("zero_latency", cyc, N);
    for (int k = 0; k < N; k++) check($sformatf("zero_pp%0d", k), pp[k], '0);
    consume();

    // Abort on cycle 3 of GEN.
    op_a = 64'h1234_5678_9ABC_DEF0;
    op_b = 64'hFEDC_BA98_7654_3210;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("abort_in_gen", pp[1] != '0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pp_valid", pp_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_pp0", pp[0], '0);
    check("abort_pp1", pp[1], '0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("abort_no_valid", pp_valid, 1'b0);
    end
    rst_n = 1'b1;
    issue(64'd5, 64'd7, cyc);
    check("abort_after_latency", cyc, N);
    check("abort_after_pp0", pp[0], 128'd35);
    check("abort_after_sum", bank_sum(), 128'd35);
    consume();

    // Short random run with random consumer stalls.
    for (int t = 0; t < 16; t++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      issue(ra, rb, cyc);
      check("rand_latency", cyc, N);
      check("rand_sum", bank_sum(), full_product(ra, rb));
      for (int s = 0; s < int'($urandom_range(3, 0)); s++) begin
        step();
        check("rand_stall_valid", pp_valid, 1'b1);
      end
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
